pht_update_scheduler: RTL
=========================

Name: pht_update_scheduler

Overview:
- Owns one single-ported table of 2-bit saturating counters (2^IWIDTH entries), the pattern-history storage behind the frontend branch predictor.
- Arbitrates the single port between same-cycle frontend lookups and retire-time updates. Updates are buffered in a small queue.
- Sequences a table-clear walk after reset and on explicit clear requests.
- Sits between the frontend prediction logic (lookup side) and branch resolution (update side).

Parameters:
- IWIDTH, 10, table index width; the table holds 2^IWIDTH counters.
- QDEPTH, 4, update queue depth; must be a power of 2, at least 2.

Ports:
- clk, input, 1, clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- en, input, 1, pipeline enable; when 0, no state changes.
- clear, input, 1, single-cycle request to flush the queue and re-clear the table.
- lookup_valid, input, 1, frontend requests a prediction this cycle.
- lookup_index, input, IWIDTH, counter index for the lookup.
- lookup_fallback, input, 1, static prediction used when the table cannot serve the lookup.
- lookup_pred, output, 1, prediction (combinational, same cycle as the lookup).
- upd_valid, input, 1, resolved branch update offered.
- upd_index, input, IWIDTH, counter index for the update.
- upd_taken, input, 1, resolved direction of the update.
- upd_ready, output, 1, queue accepts the update this cycle.
- busy, output, 1, clear walk in progress.
- q_level, output, $clog2(QDEPTH)+1, current queue occupancy.
- fallback_count, output, 16, saturating count of lookups served by fallback in RUN.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM enters CLEAR, clr_ptr=0, queue empty, fallback_count=0.
  - Outputs: busy=1, upd_ready=0, q_level=0, lookup_pred=lookup_fallback.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. Prediction = bit[1]. Clear value is 2'b01.
- en=0:
  - FSM, clr_ptr, queue, table and fallback_count hold.
  - upd_ready=0.
  - lookup_pred is still driven combinationally.
- State CLEAR (busy=1):
  - Each en cycle writes 2'b01 to counter[clr_ptr], then clr_ptr++.
  - The cycle that writes index 2^IWIDTH-1 transitions to RUN, so a full clear takes exactly 2^IWIDTH en cycles.
  - upd_ready=0 and lookup_pred=lookup_fallback throughout.
  - fallback_count does not increment in CLEAR.
  - clear asserted in CLEAR restarts clr_ptr=0.
- State RUN (busy=0):
  - upd_ready = (q_level != QDEPTH) & en.
  - Push happens when upd_valid & upd_ready; the entry is {upd_index, upd_taken}, appended at the tail.
  - full = (q_level == QDEPTH), sampled from the current cycle's registered level.
- Port grant, one access per en cycle, priority order:
  1. full & lookup_valid → forced drain:
     - pop the head and apply it;
     - lookup_pred=lookup_fallback;
     - fallback_count++ (saturates at 16'hFFFF).
  2. lookup_valid → lookup:
     - lookup_pred=counter[lookup_index][1];
     - queue holds.
  3. queue non-empty → pop the head and apply it (read-modify-write):
     - taken: cnt = (cnt==3) ? 3 : cnt+1;
     - not taken: cnt = (cnt==0) ? 0 : cnt-1.
  4. Otherwise idle. With lookup_valid=0, lookup_pred=lookup_fallback.
- Push and pop in the same cycle are allowed. q_level is unchanged in that case; the push lands at the tail, and the pop takes the old head.
- A push is never applied in its own cycle. Minimum update latency is 1 cycle: the update is visible to a lookup two cycles after acceptance.
- Lookups do not check pending queue entries. A stale read is permitted behaviour, not an error.
- Pointers wrap modulo QDEPTH. Occupancy is tracked in a counter of width $clog2(QDEPTH)+1.
- clear in RUN, with en=1:
  - the queue is flushed (q_level=0 next cycle); pending updates are discarded;
  - clr_ptr=0, FSM goes to CLEAR;
  - any push or pop in that same cycle is discarded.
- clear with en=0 is ignored.
- Reset mid-operation aborts everything immediately, including a clear in progress or a pending drain.

Test Plan (IWIDTH=4, QDEPTH=4):
1. Release reset with en=1, lookup_valid=1, idx 5, fallback=1 → busy=1 and lookup_pred=1 for 16 cycles; in cycle 17 busy=0 and lookup_pred=0 (counter 01).
2. In RUN with lookup_valid=0, push three taken updates to idx 5 on consecutive cycles → q_level peaks at 1; a later lookup of idx 5 gives pred=1 and internal counter=3. A fourth taken update leaves it at 3. Then four not-taken updates → counter=0, pred=0.
3. Hold lookup_valid=1 and push 4 updates → q_level reaches 4 and upd_ready=0. The next cycle force-drains: lookup_pred=lookup_fallback, fallback_count=1, q_level=3, upd_ready=1 the following cycle.
4. Simultaneous push and pop at q_level=2 (lookup_valid=0) → q_level stays 2; entries apply in FIFO order (verify with alternating indices 3 and 9).
5. clear at q_level=2 in RUN → next cycle q_level=0 and busy=1 for 16 en cycles; all counters read back 01. Queued updates are never applied.
6. en=0 for 3 cycles in the middle of CLEAR → clr_ptr frozen and busy extended by exactly 3 cycles. Then assert reset asynchronously mid-drain → q_level=0 and busy=1 immediately, with no clock edge required.

Source files
------------

// File: rtl/pht_update_scheduler.sv
// pht_update_scheduler
//   Owns a single-ported table of 2-bit saturating counters (2^IWIDTH entries)
//   used as pattern-history storage for the frontend branch predictor. The one
//   table port is shared between same-cycle frontend lookups and retire-time
//   updates. Updates wait in a small FIFO. After reset, and on request, a clear
//   walk rewrites every counter to weak-not-taken (2'b01).
//
// Ports
//   clk, reset        : clock and asynchronous active-high reset
//   en                : pipeline enable; when low, no state changes
//   clear             : one-cycle request to flush the queue and re-clear the table
//   lookup_valid/index/fallback, lookup_pred
//                     : prediction request and its combinational answer
//   upd_valid/index/taken, upd_ready
//                     : resolved-branch update handshake into the queue
//   busy              : clear walk in progress (this is exactly state == CLEAR)
//   q_level           : queue occupancy
//   fallback_count    : saturating count of lookups answered by fallback due to
//                       a forced drain
//
// Update handshake: an update transfers on any cycle where upd_valid and
// upd_ready are both high. upd_ready never depends on upd_valid. Once it is
// accepted, the entry is applied in FIFO order on a later cycle.

module pht_update_scheduler #(
    parameter int IWIDTH = 10,
    parameter int QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     lookup_valid,
    input  logic [IWIDTH-1:0]        lookup_index,
    input  logic                     lookup_fallback,
    output logic                     lookup_pred,
    input  logic                     upd_valid,
    input  logic [IWIDTH-1:0]        upd_index,
    input  logic                     upd_taken,
    output logic                     upd_ready,
    output logic                     busy,
    output logic [$clog2(QDEPTH):0]  q_level,
    output logic [15:0]              fallback_count
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int LW   = PW + 1;
    localparam int EW   = IWIDTH + 1;
    localparam int NENT = 1 << IWIDTH;
    localparam logic [LW-1:0] FULL_LVL = LW'(QDEPTH);
    localparam logic [1:0]    CLR_VAL  = 2'b01;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IWIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [LW-1:0]       level_q, level_d;
    logic [15:0]         fb_cnt_q, fb_cnt_d;

    logic [EW-1:0]       queue_q [QDEPTH];
    logic [1:0]          table_q [NENT];

    logic                full, empty, in_run, act_run;
    logic                push, pop, forced;
    logic [EW-1:0]       head_entry;
    logic [IWIDTH-1:0]   h_idx;
    logic                h_taken;
    logic [1:0]          h_cnt, h_cnt_upd;
    logic                tbl_we;
    logic [IWIDTH-1:0]   tbl_waddr;
    logic [1:0]          tbl_wdata;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign in_run  = (state_q == ST_RUN);
    // A RUN cycle that actually grants the port; a clear in the same cycle
    // discards any push or pop.
    assign act_run = in_run & en & ~clear;

    assign upd_ready = in_run & en & ~full;
    assign push      = upd_valid & upd_ready & ~clear;
    // A lookup normally wins the port; when the queue is full it is answered
    // by fallback so the head can drain and the queue cannot deadlock.
    assign forced    = act_run & full & lookup_valid;
    assign pop       = forced | (act_run & ~lookup_valid & ~empty);

    assign busy           = (state_q == ST_CLEAR);
    assign q_level        = level_q;
    assign fallback_count = fb_cnt_q;

    always_comb begin
        lookup_pred = lookup_fallback;
        if (in_run && lookup_valid && !full) begin
            lookup_pred = table_q[lookup_index][1];
        end
    end

    // Head read-modify-write: saturating counter step.
    always_comb begin
        head_entry = queue_q[head_q];
        h_idx      = head_entry[EW-1:1];
        h_taken    = head_entry[0];
        h_cnt      = table_q[h_idx];
        h_cnt_upd  = h_cnt;
        if (h_taken) begin
            if (h_cnt != 2'd3) h_cnt_upd = h_cnt + 2'd1;
        end else begin
            if (h_cnt != 2'd0) h_cnt_upd = h_cnt - 2'd1;
        end
    end

    // Table write port: the clear walk and the queue drain never overlap
    // because they happen in different states.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_waddr = '0;
        tbl_wdata = CLR_VAL;
        if (!in_run && en && !clear) begin
            tbl_we    = 1'b1;
            tbl_waddr = clr_ptr_q;
            tbl_wdata = CLR_VAL;
        end else if (pop) begin
            tbl_we    = 1'b1;
            tbl_waddr = h_idx;
            tbl_wdata = h_cnt_upd;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        head_d    = head_q;
        tail_d    = tail_q;
        level_d   = level_q;
        fb_cnt_d  = fb_cnt_q;
        if (en) begin
            case (state_q)
                ST_CLEAR: begin
                    if (clear) begin
                        clr_ptr_d = '0;
                    end else begin
                        clr_ptr_d = clr_ptr_q + 1'b1;
                        if (clr_ptr_q == '1) state_d = ST_RUN;
                    end
                end
                default: begin
                    if (clear) begin
                        state_d   = ST_CLEAR;
                        clr_ptr_d = '0;
                        head_d    = '0;
                        tail_d    = '0;
                        level_d   = '0;
                    end else begin
                        if (push) tail_d = tail_q + 1'b1;
                        if (pop)  head_d = head_q + 1'b1;
                        level_d = level_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
                        if (forced && fb_cnt_q != 16'hFFFF) fb_cnt_d = fb_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            level_q   <= '0;
            fb_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            level_q   <= level_d;
            fb_cnt_q  <= fb_cnt_d;
        end
    end

    // Storage arrays carry no reset: the queue is guarded by the pointers and
    // the table is rewritten by the clear walk that follows every reset.
    always_ff @(posedge clk) begin
        if (push) queue_q[tail_q] <= {upd_index, upd_taken};
    end

    always_ff @(posedge clk) begin
        if (tbl_we) table_q[tbl_waddr] <= tbl_wdata;
    end

endmodule
